// File: rtl/player_frame_ctrl_if.sv
// Avalon-MM register bus for player_frame_ctrl.
// master: drives chipselect/write/read/address/writedata, receives readdata.
// slave : the controller; returns readdata one cycle after a read strobe.
interface player_frame_ctrl_if;
    localparam int unsigned AW = 3;
    localparam int unsigned DW = 8;

    logic          chipselect;
    logic          write;
    logic          read;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;

    modport master (
        output chipselect,
        output write,
        output read,
        output address,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  write,
        input  read,
        input  address,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/player_frame_ctrl.sv
// Frame-synchronous controller for the player sprite / VGA datapath.
// Software stages player position and scroll step over the Avalon slave and
// arms a commit; staged values reach the active outputs only at vblank start,
// so a visible frame never tears. Also keeps a frame counter, advances the
// horizontal scroll each frame and raises a level frame-done interrupt.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   bus (slave modport)   Avalon chipselect/write/read/address/writedata/readdata
//   vcount                line counter from vga_counters
//   player_x, player_y    active (committed, clamped) player position
//   scroll                active scroll offset, 0..SCROLL_WRAP-1
//   irq                   frame-done interrupt (irq_pend & irq_en)
//
// Build option: define SCROLL_EN to include the step register and scroll
// accumulator; without it scroll is tied to 0 and address 4 is inert.
module player_frame_ctrl #(
    parameter int unsigned VACTIVE     = 480,
    parameter int unsigned XMAX        = 639,
    parameter int unsigned YMAX        = 479,
    parameter int unsigned SCROLL_WRAP = 640
) (
    input  logic                     clk,
    input  logic                     reset_n,
    player_frame_ctrl_if.slave       bus,
    input  logic [9:0]               vcount,
    output logic [9:0]               player_x,
    output logic [9:0]               player_y,
    output logic [9:0]               scroll,
    output logic                     irq
);
    localparam int unsigned CW = 10;   // coordinate width
    localparam int unsigned DW = 8;    // bus data width
    localparam int unsigned FW = 8;    // frame counter width
`ifdef SCROLL_EN
    localparam int unsigned SW = 11;   // scroll sum width (no overflow)
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    state_e          state_q,     state_d;
    logic [CW-1:0]   stage_x_q,   stage_x_d;
    logic [CW-1:0]   stage_y_q,   stage_y_d;
    logic [CW-1:0]   player_x_q,  player_x_d;
    logic [CW-1:0]   player_y_q,  player_y_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [DW-1:0]   readdata_q,  readdata_d;
    logic            irq_en_q,    irq_en_d;
    logic            irq_pend_q,  irq_pend_d;
    logic            irq_q,       irq_d;
    logic            vb_q,        vb_d;
`ifdef SCROLL_EN
    logic [DW-1:0]   step_q,      step_d;
    logic [CW-1:0]   scroll_q,    scroll_d;
    logic [SW-1:0]   scroll_sum;
`endif

    logic wr_en;
    logic rd_en;
    logic vb_now;
    logic vb_start;
    logic ctrl_wr;
    logic commit_req;

    // Bus decode and vblank edge detect
    assign wr_en      = bus.chipselect & bus.write;
    assign rd_en      = bus.chipselect & bus.read;
    assign vb_now     = (vcount >= CW'(VACTIVE));
    assign vb_start   = vb_now & ~vb_q;
    assign ctrl_wr    = wr_en && (bus.address == 3'd5);
    assign commit_req = ctrl_wr && bus.writedata[0];

`ifdef SCROLL_EN
    // SCROLL_WRAP > 255 guarantees one subtraction is enough
    assign scroll_sum = SW'(scroll_q) + SW'(step_q);
`endif

    // Next-state logic for all registers
    always_comb begin
        state_d     = state_q;
        stage_x_d   = stage_x_q;
        stage_y_d   = stage_y_q;
        player_x_d  = player_x_q;
        player_y_d  = player_y_q;
        frame_cnt_d = frame_cnt_q;
        readdata_d  = readdata_q;
        irq_en_d    = irq_en_q;
        irq_pend_d  = irq_pend_q;
        vb_d        = vb_now;
`ifdef SCROLL_EN
        step_d      = step_q;
        scroll_d    = scroll_q;
`endif

        // Staging writes are accepted in every state
        if (wr_en) begin
            case (bus.address)
                3'd0: stage_x_d[7:0] = bus.writedata;
                3'd1: stage_x_d[9:8] = bus.writedata[1:0];
                3'd2: stage_y_d[7:0] = bus.writedata;
                3'd3: stage_y_d[9:8] = bus.writedata[1:0];
`ifdef SCROLL_EN
                3'd4: step_d         = bus.writedata;
`endif
                3'd5: begin
                    irq_en_d = bus.writedata[1];
                    if (bus.writedata[2]) begin
                        irq_pend_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // Per-frame bookkeeping
        if (vb_start) begin
            frame_cnt_d = frame_cnt_q + FW'(1);
`ifdef SCROLL_EN
            scroll_d = (scroll_sum >= SW'(SCROLL_WRAP))
                     ? CW'(scroll_sum - SW'(SCROLL_WRAP))
                     : CW'(scroll_sum);
`endif
        end

        // Commit FSM; COMMIT reads stage_*_q so a write in that cycle waits
        case (state_q)
            IDLE: begin
                if (commit_req) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (vb_start) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                player_x_d = (stage_x_q > CW'(XMAX)) ? CW'(XMAX) : stage_x_q;
                player_y_d = (stage_y_q > CW'(YMAX)) ? CW'(YMAX) : stage_y_q;
                irq_pend_d = 1'b1;   // overrides a same-cycle clear
                state_d    = commit_req ? ARMED : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Read mux, one cycle latency, held between reads
        if (rd_en) begin
            case (bus.address)
                3'd0: readdata_d = stage_x_q[7:0];
                3'd1: readdata_d = {6'b0, stage_x_q[9:8]};
                3'd2: readdata_d = stage_y_q[7:0];
                3'd3: readdata_d = {6'b0, stage_y_q[9:8]};
`ifdef SCROLL_EN
                3'd4: readdata_d = step_q;
`endif
                3'd5: readdata_d = {5'b0, irq_en_q, irq_pend_q, (state_q == ARMED)};
                3'd6: readdata_d = frame_cnt_q;
                default: readdata_d = '0;
            endcase
        end
    end

    assign irq_d = irq_pend_d & irq_en_d;

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            stage_x_q   <= '0;
            stage_y_q   <= '0;
            player_x_q  <= '0;
            player_y_q  <= '0;
            frame_cnt_q <= '0;
            readdata_q  <= '0;
            irq_en_q    <= 1'b0;
            irq_pend_q  <= 1'b0;
            irq_q       <= 1'b0;
            vb_q        <= 1'b0;
`ifdef SCROLL_EN
            step_q      <= '0;
            scroll_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            stage_x_q   <= stage_x_d;
            stage_y_q   <= stage_y_d;
            player_x_q  <= player_x_d;
            player_y_q  <= player_y_d;
            frame_cnt_q <= frame_cnt_d;
            readdata_q  <= readdata_d;
            irq_en_q    <= irq_en_d;
            irq_pend_q  <= irq_pend_d;
            irq_q       <= irq_d;
            vb_q        <= vb_d;
`ifdef SCROLL_EN
            step_q      <= step_d;
            scroll_q    <= scroll_d;
`endif
        end
    end

    assign player_x     = player_x_q;
    assign player_y     = player_y_q;
    assign irq          = irq_q;
    assign bus.readdata = readdata_q;
`ifdef SCROLL_EN
    assign scroll       = scroll_q;
`else
    assign scroll       = '0;
`endif

endmodule

// File: tb/tb_player_frame_ctrl.sv
// Directed self-checking bench for player_frame_ctrl.
module tb_player_frame_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] vcount;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [9:0] scroll;
    logic       irq;

    int n_checks = 0;
    int n_errors = 0;

    player_frame_ctrl_if bus ();

    player_frame_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .vcount   (vcount),
        .player_x (player_x),
        .player_y (player_y),
        .scroll   (scroll),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.read = 1'b0;
        d = bus.readdata;
    endtask

    // One vblank: vcount sits at VACTIVE for several cycles, then returns
    task automatic run_frame();
        @(negedge clk); vcount = 10'd480;
        repeat (4) @(negedge clk);
        vcount = 10'd100;
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0; vcount = 10'd0;
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        reset_n = 1'b0; vcount = 10'd300;
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
        bus.address = '0; bus.writedata = '0;
        #3;
        n_checks++;
        if ({player_x, player_y, scroll, irq, bus.readdata} !== 39'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: x=%0d y=%0d scroll=%0d irq=%b rd=%h required all 0",
                     player_x, player_y, scroll, irq, bus.readdata);
        end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        bus_read(3'd5, rd);
        n_checks++;
        if (rd !== 8'h00) begin n_errors++; $display("FAIL reset_status: got %h required 00", rd); end
        bus_read(3'd6, rd);
        n_checks++;
        if (rd !== 8'h00) begin n_errors++; $display("FAIL reset_frame_cnt: got %h required 00", rd); end
    endtask

    task automatic test_commit();
        logic [7:0] rd;
        vcount = 10'd100;
        bus_write(3'd0, 8'h2C);
        bus_write(3'd1, 8'h01);
        bus_write(3'd2, 8'hC8);
        bus_write(3'd3, 8'h00);
        bus_write(3'd5, 8'h03);
        bus_read(3'd5, rd);
        n_checks++;
        if (rd !== 8'h05) begin n_errors++; $display("FAIL commit_armed_status: got %h required 05", rd); end
        @(negedge clk); vcount = 10'd480;
        @(negedge clk);
        n_checks++;
        if (player_x !== 10'd0 || player_y !== 10'd0) begin
            n_errors++; $display("FAIL commit_early: x=%0d y=%0d required 0/0", player_x, player_y);
        end
        @(negedge clk);
        n_checks++;
        if (player_x !== 10'd300 || player_y !== 10'd200) begin
            n_errors++; $display("FAIL commit_value: x=%0d y=%0d required 300/200", player_x, player_y);
        end
        n_checks++;
        if (irq !== 1'b1) begin n_errors++; $display("FAIL commit_irq: got %b required 1", irq); end
        @(negedge clk); vcount = 10'd100;
        bus_read(3'd5, rd);
        n_checks++;
        if (rd !== 8'h06) begin n_errors++; $display("FAIL commit_pend_status: got %h required 06", rd); end
        bus_write(3'd5, 8'h06);
        n_checks++;
        if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_clear: got %b required 0", irq); end
        bus_read(3'd5, rd);
        n_checks++;
        if (rd !== 8'h04) begin n_errors++; $display("FAIL irq_clear_status: got %h required 04", rd); end
    endtask

    task automatic test_clamp();
        logic [7:0] rd;
        bus_write(3'd0, 8'hE8);
        bus_write(3'd1, 8'h03);
        bus_write(3'd2, 8'h58);
        bus_write(3'd3, 8'h02);
        bus_write(3'd5, 8'h01);
        run_frame();
        n_checks++;
        if (player_x !== 10'd639 || player_y !== 10'd479) begin
            n_errors++; $display("FAIL clamp: x=%0d y=%0d required 639/479", player_x, player_y);
        end
        n_checks++;
        if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_masked: got %b required 0", irq); end
        bus_read(3'd5, rd);
        n_checks++;
        if (rd !== 8'h02) begin n_errors++; $display("FAIL masked_status: got %h required 02", rd); end
        bus_read(3'd1, rd);
        n_checks++;
        if (rd !== 8'h03) begin n_errors++; $display("FAIL read_stage_xh: got %h required 03", rd); end
        bus_read(3'd3, rd);
        n_checks++;
        if (rd !== 8'h02) begin n_errors++; $display("FAIL read_stage_yh: got %h required 02", rd); end
    endtask

    task automatic test_race_commit_vb();
        logic [7:0] rd;
        bus_write(3'd0, 8'h05);
        bus_write(3'd1, 8'h00);
        bus_write(3'd2, 8'h07);
        bus_write(3'd3, 8'h00);
        @(negedge clk);
        vcount = 10'd480;
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 3'd5; bus.writedata = 8'h01;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (player_x !== 10'd639) begin
            n_errors++; $display("FAIL race_vb_no_update: x=%0d required 639", player_x);
        end
        vcount = 10'd100;
        bus_read(3'd5, rd);
        n_checks++;
        if (rd !== 8'h03) begin n_errors++; $display("FAIL race_vb_armed: got %h required 03", rd); end
        run_frame();
        n_checks++;
        if (player_x !== 10'd5 || player_y !== 10'd7) begin
            n_errors++; $display("FAIL race_vb_next_frame: x=%0d y=%0d required 5/7", player_x, player_y);
        end
    endtask

    task automatic test_race_stage_commit();
        logic [7:0] rd;
        bus_write(3'd0, 8'h0A);
        bus_write(3'd5, 8'h01);
        @(negedge clk); vcount = 10'd480;
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 3'd0; bus.writedata = 8'h99;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write = 1'b0;
        n_checks++;
        if (player_x !== 10'd10) begin
            n_errors++; $display("FAIL race_stage_old_value: x=%0d required 10", player_x);
        end
        vcount = 10'd100;
        bus_read(3'd0, rd);
        n_checks++;
        if (rd !== 8'h99) begin n_errors++; $display("FAIL race_stage_staged: got %h required 99", rd); end
        bus_write(3'd5, 8'h01);
        run_frame();
        n_checks++;
        if (player_x !== 10'd153) begin
            n_errors++; $display("FAIL race_stage_next_commit: x=%0d required 153", player_x);
        end
    endtask

    task automatic test_irq_race();
        logic [7:0] rd;
        bus_write(3'd5, 8'h03);
        @(negedge clk); vcount = 10'd480;
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 3'd5; bus.writedata = 8'h06;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write = 1'b0;
        n_checks++;
        if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_set_wins: got %b required 1", irq); end
        vcount = 10'd100;
        bus_read(3'd5, rd);
        n_checks++;
        if (rd !== 8'h06) begin n_errors++; $display("FAIL irq_race_status: got %h required 06", rd); end
    endtask

    task automatic test_scroll();
        logic [7:0] rd;
        logic [9:0] exp_scroll [4];
        logic [7:0] exp_step;
`ifdef SCROLL_EN
        exp_scroll = '{10'd200, 10'd400, 10'd600, 10'd160};
        exp_step   = 8'd200;
`else
        exp_scroll = '{10'd0, 10'd0, 10'd0, 10'd0};
        exp_step   = 8'd0;
`endif
        apply_reset();
        bus_write(3'd4, 8'd200);
        bus_read(3'd4, rd);
        n_checks++;
        if (rd !== exp_step) begin n_errors++; $display("FAIL step_read: got %0d required %0d", rd, exp_step); end
        for (int i = 0; i < 4; i++) begin
            run_frame();
            n_checks++;
            if (scroll !== exp_scroll[i]) begin
                n_errors++; $display("FAIL scroll_frame%0d: got %0d required %0d", i + 1, scroll, exp_scroll[i]);
            end
        end
        bus_read(3'd6, rd);
        n_checks++;
        if (rd !== 8'd4) begin n_errors++; $display("FAIL frame_cnt_4: got %0d required 4", rd); end
    endtask

    task automatic test_frame_wrap();
        logic [7:0] rd;
        apply_reset();
        for (int i = 0; i < 255; i++) begin
            run_frame();
            n_checks++;
            if (scroll !== 10'd0) begin
                n_errors++; $display("FAIL wrap_scroll_zero: frame %0d got %0d required 0", i + 1, scroll);
            end
        end
        bus_read(3'd6, rd);
        n_checks++;
        if (rd !== 8'hFF) begin n_errors++; $display("FAIL frame_cnt_255: got %h required ff", rd); end
        run_frame();
        bus_read(3'd6, rd);
        n_checks++;
        if (rd !== 8'h00) begin n_errors++; $display("FAIL frame_cnt_wrap: got %h required 00", rd); end
        bus_read(3'd7, rd);
        n_checks++;
        if (rd !== 8'h00) begin n_errors++; $display("FAIL read_addr7: got %h required 00", rd); end
    endtask

    task automatic test_reset_mid_commit();
        logic [7:0] rd;
        bus_write(3'd0, 8'h2C);
        bus_write(3'd1, 8'h01);
        bus_write(3'd5, 8'h03);
        run_frame();
        n_checks++;
        if (player_x !== 10'd300 || irq !== 1'b1) begin
            n_errors++; $display("FAIL pre_reset_commit: x=%0d irq=%b required 300/1", player_x, irq);
        end
        bus_read(3'd0, rd);
        bus_write(3'd0, 8'h40);
        bus_write(3'd5, 8'h03);
        @(negedge clk); vcount = 10'd480;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({player_x, player_y, scroll, irq, bus.readdata} !== 39'd0) begin
            n_errors++;
            $display("FAIL reset_mid_commit: x=%0d y=%0d scroll=%0d irq=%b rd=%h required all 0",
                     player_x, player_y, scroll, irq, bus.readdata);
        end
        @(negedge clk);
        reset_n = 1'b1; vcount = 10'd100;
        run_frame();
        n_checks++;
        if (player_x !== 10'd0) begin
            n_errors++; $display("FAIL commit_abandoned: x=%0d required 0", player_x);
        end
        bus_read(3'd5, rd);
        n_checks++;
        if (rd !== 8'h00) begin n_errors++; $display("FAIL post_reset_status: got %h required 00", rd); end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_clamp();
        test_race_commit_vb();
        test_race_stage_commit();
        test_irq_race();
        test_reset_mid_commit();
        test_scroll();
        test_frame_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
